// File: rtl/jackpot_pkg.sv
// Shared types and LED patterns for the jackpot board sequencer.
package jackpot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        WIN  = 2'd2,
        MISS = 2'd3
    } state_t;

    localparam logic [3:0] FIRST       = 4'b0001;
    localparam logic [3:0] SECOND      = 4'b0010;
    localparam logic [3:0] THIRD       = 4'b0100;
    localparam logic [3:0] FOURTH      = 4'b1000;
    localparam logic [3:0] WIN_PATTERN = 4'b1111;
    localparam logic [3:0] OFF         = 4'b0000;

    // Advance the lit LED one place: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
    function automatic logic [3:0] rotate_led(input logic [3:0] led);
        return {led[2:0], led[3]};
    endfunction

endpackage

// File: rtl/jackpot_edge.sv
// Two-flop synchronizer followed by a rising-edge detector, one flag per bit.
module jackpot_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/jackpot_ctrl.sv
// Jackpot game sequencer: rotating LED, hit/miss judging, speed levels.
// Optional JACKPOT_BLINK_EN: WIN blinks 1111/0000 each step instead of solid 1111.
module jackpot_ctrl
    import jackpot_pkg::*;
#(
    parameter int CLK_DIV    = 25_000_000,
    parameter int LEVELS     = 4,
    parameter int MISS_STEPS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 trigger,
    output logic [3:0]                 out,
    output logic [$clog2(LEVELS)-1:0]  level,
    output logic                       winPulse
);

    localparam int LVL_W = $clog2(LEVELS);
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int MS_W  = $clog2(MISS_STEPS + 1);
    localparam logic [LVL_W-1:0] LVL_MAX     = LVL_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0] MISS_TC     = CNT_W'(CLK_DIV - 1);
    localparam logic [MS_W-1:0]  MISS_LAST   = MS_W'(MISS_STEPS - 1);

    logic [3:0] trig_rise;
    logic [0:0] start_rise;

    jackpot_edge #(.WIDTH(4)) u_trig_edge (
        .clock (clock),
        .reset (reset),
        .din   (trigger),
        .rise  (trig_rise)
    );

    jackpot_edge #(.WIDTH(1)) u_start_edge (
        .clock (clock),
        .reset (reset),
        .din   (start),
        .rise  (start_rise)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pos_q, pos_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [MS_W-1:0]  miss_q, miss_d;
    logic [3:0]       out_q, out_d;
    logic             win_pulse_q, win_pulse_d;
`ifdef JACKPOT_BLINK_EN
    logic             blink_q, blink_d;
`endif

    logic [CNT_W-1:0] period_m1;
    logic             step;

    assign period_m1 = CNT_W'((CLK_DIV >> level_q) - 1);
    assign step      = (cnt_q == period_m1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        level_d     = level_q;
        miss_d      = miss_q;
        win_pulse_d = 1'b0;
`ifdef JACKPOT_BLINK_EN
        blink_d     = blink_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_rise[0]) begin
                    state_d = SPIN;
                    pos_d   = FIRST;
                    cnt_d   = '0;
                end
            end
            SPIN: begin
                // A press is judged against the LED lit before any step taken this cycle.
                if (trig_rise != OFF) begin
                    cnt_d = '0;
                    if (trig_rise == pos_q) begin
                        state_d     = WIN;
                        win_pulse_d = 1'b1;
                        if (level_q != LVL_MAX) begin
                            level_d = level_q + 1'b1;
                        end
`ifdef JACKPOT_BLINK_EN
                        blink_d = 1'b1;
`endif
                    end else begin
                        state_d = MISS;
                        level_d = '0;
                        miss_d  = '0;
                    end
                end else if (step) begin
                    cnt_d = '0;
                    pos_d = rotate_led(pos_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WIN: begin
                if (start_rise[0]) begin
                    state_d = SPIN;
                    pos_d   = FIRST;
                    cnt_d   = '0;
                end else begin
`ifdef JACKPOT_BLINK_EN
                    if (step) begin
                        cnt_d   = '0;
                        blink_d = ~blink_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            MISS: begin
                // Dark period is timed at the level-0 rate regardless of the level lost.
                if (cnt_q == MISS_TC) begin
                    cnt_d = '0;
                    if (miss_q == MISS_LAST) begin
                        state_d = SPIN;
                        pos_d   = FIRST;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            SPIN:    out_d = pos_d;
`ifdef JACKPOT_BLINK_EN
            WIN:     out_d = blink_d ? WIN_PATTERN : OFF;
`else
            WIN:     out_d = WIN_PATTERN;
`endif
            default: out_d = OFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pos_q       <= FIRST;
            level_q     <= '0;
            miss_q      <= '0;
            out_q       <= OFF;
            win_pulse_q <= 1'b0;
`ifdef JACKPOT_BLINK_EN
            blink_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            level_q     <= level_d;
            miss_q      <= miss_d;
            out_q       <= out_d;
            win_pulse_q <= win_pulse_d;
`ifdef JACKPOT_BLINK_EN
            blink_q     <= blink_d;
`endif
        end
    end

    assign out      = out_q;
    assign level    = level_q;
    assign winPulse = win_pulse_q;

endmodule
